muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, replacing the combinational multiplier and delay-based divider in the MIPS datapath's secondary ALU path. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO under a start/busy/done handshake, and holds HI/LO for MFHI/MFLO reads. The datapath stalls the PC and register writeback while `busy` is high.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be at least 4 and even.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; others are no-ops.
- `a` in WIDTH: rs operand (multiplicand/dividend, MTHI/MTLO data).
- `b` in WIDTH: rt operand (multiplier/divisor).
- `flush` in 1: abort the in-flight operation.
- `busy` out 1: operation in progress; the datapath must stall.
- `done` out 1: one-cycle pulse when HI/LO receive a mul/div result.
- `dbz` out 1: divide-by-zero; valid only with `done`.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- **States:**
  - IDLE → RUN on `start` with a mul/div op.
  - RUN → FIX after exactly WIDTH iterations.
  - FIX → IDLE unconditionally.
- **MTHI/MTLO:** with `start` in IDLE, `hi` (or `lo`) takes `a` at that edge. The state stays IDLE, `busy` stays 0 and no `done` is raised.
- **Accept (IDLE, mul/div op):** latch |a|, |b| (magnitudes for signed ops, raw values for unsigned) and the result sign flags. Clear the accumulator and the iteration counter.
- **RUN, multiply:** shift-add, one multiplier bit per cycle. The product is 2·WIDTH bits.
- **RUN, divide:** restoring, one quotient bit per cycle.
- **FIX (sign fixup):**
  - Product is negated if sign(a) XOR sign(b).
  - Quotient is negated if sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
  - HI/LO are written at the FIX→IDLE edge: multiply gives HI=upper, LO=lower; divide gives HI=remainder, LO=quotient.
- **Divide by zero** (b==0, DIVU or DIV):
  - LO = all ones, HI = a (raw dividend); `dbz`=1 with `done`.
  - Full latency is still taken, so timing is uniform.
- **Signed overflow** (DIV of most-negative by −1): LO = most-negative, HI = 0, `dbz`=0. This falls out of the magnitude algorithm without special casing.
- **`start` while busy:** ignored; it is not queued.
- **`flush`:** from any state, return to IDLE next edge with HI/LO unchanged and no `done`. `flush` with `start` in IDLE suppresses the accept.
- **Reset mid-operation:** state IDLE, HI=LO=0, `busy`=`done`=`dbz`=0.

## Timing
- Accept edge = edge 0.
- `busy`=1 from after edge 0 through the FIX cycle: WIDTH+1 cycles.
- HI/LO update, `done`=1 and `busy`=0 all take effect after edge WIDTH+1. Latency is WIDTH+2 cycles from `start` to the `done` cycle, i.e. `done` in cycle 34 for WIDTH=32.
- Back-to-back: a new `start` is accepted in the same cycle `done` is high.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `dbz`=0.

## Structure
- **Package `muldiv_pkg`:** op encoding constants, the state enum (IDLE, RUN, FIX), and a counter-width function of WIDTH.
- **Sub-module `muldiv_step`:** combinational single-iteration datapath; one shift-add or restore-subtract step selected by the op class. The top level holds the FSM, counter, operand/accumulator registers, fixup and HI/LO.

## Test plan
All scenarios use WIDTH=32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` in cycle 34; `busy` high cycles 1–33.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064, `dbz`=1. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, `dbz`=0.
- Handshake and abort:
  - MTHI 0x1234 in IDLE → `hi`=0x1234 next cycle, `busy` never rises.
  - `start` at cycle 5 of a MULT → ignored.
  - `flush` at cycle 10 → IDLE next cycle, HI/LO keep their prior values, no `done`.
- Reset asserted at cycle 20 of a DIVU → next cycle all outputs are 0; a fresh MULTU 6×7 then gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and sizing helper for the iterative multiply/divide unit.
package muldiv_pkg;
    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // Iteration counter runs 0..width-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply step or one restoring-divide step.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] mq_n
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    // Divisor of zero always "fits", so the quotient fills with ones and acc rebuilds the dividend.
    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, m} : '0);
        rem_sh  = {acc, mq[WIDTH-1]};
        ge      = rem_sh >= {1'b0, m};
        rem_sub = rem_sh[WIDTH-1:0] - m;
        acc_n   = is_div ? (ge ? rem_sub : rem_sh[WIDTH-1:0]) : sum[WIDTH:1];
        mq_n    = is_div ? {mq[WIDTH-2:0], ge} : {sum[0], mq[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, sa_q, sa_d, dz_q, dz_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic             idle_go, accept, run, commit, last, sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b, step_acc, step_mq, quo, rem;
    logic [2*WIDTH-1:0] prod, prod_f;

    assign idle_go = (state_q == IDLE) & start & ~flush;
    assign accept  = idle_go & ~op[2];
    assign run     = (state_q == RUN) & ~flush;
    assign commit  = (state_q == FIX) & ~flush;
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign sa      = op[0] & a[WIDTH-1];
    assign sb      = op[0] & b[WIDTH-1];
    assign abs_a   = sa ? -a : a;
    assign abs_b   = sb ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .acc    (acc_q),
        .mq     (mq_q),
        .m      (m_q),
        .acc_n  (step_acc),
        .mq_n   (step_mq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = flush ? IDLE :
                  (state_q == IDLE) ? (accept ? RUN : IDLE) :
                  (state_q == RUN) ? (last ? FIX : RUN) : IDLE;
    end

    always_comb begin
        busy_d = state_d != IDLE;
        done_d = commit;
        dbz_d  = commit & dz_q;
    end

    // Sign fixup: product/quotient follow sign(a)^sign(b), remainder follows the dividend.
    always_comb begin
        prod     = {acc_q, mq_q};
        prod_f   = neg_q ? -prod : prod;
        quo      = dz_q ? '1 : (neg_q ? -mq_q : mq_q);
        rem      = sa_q ? -acc_q : acc_q;
        cnt_d    = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
        acc_d    = accept ? '0 : run ? step_acc : acc_q;
        mq_d     = accept ? (op[1] ? abs_a : abs_b) : run ? step_mq : mq_q;
        m_d      = accept ? (op[1] ? abs_b : abs_a) : m_q;
        is_div_d = accept ? op[1] : is_div_q;
        neg_d    = accept ? sa ^ sb : neg_q;
        sa_d     = accept ? sa : sa_q;
        dz_d     = accept ? op[1] & (b == '0) : dz_q;
        hi_d     = (idle_go & (op == OP_MTHI)) ? a :
                   commit ? (is_div_q ? rem : prod_f[2*WIDTH-1:WIDTH]) : hi_q;
        lo_d     = (idle_go & (op == OP_MTLO)) ? a :
                   commit ? (is_div_q ? quo : prod_f[WIDTH-1:0]) : lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
